motion_sequencer: RTL and testbench
===================================

MOTION_SEQUENCER -- requirements
Module: motion_sequencer

Interface
REQ-001 SHALL have parameter PULSE_W, default 4, step high time in CLK cycles (min 1).
REQ-002 SHALL have parameter DIR_SETUP, default 2, CLK cycles dir must be stable before a step rising edge (min 1).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  move command offered.
REQ-006 SHALL have port cmd_ready  output  1  pending slot empty; command accepted when cmd_valid && cmd_ready at a CLK edge.
REQ-007 SHALL have port cmd_steps  input  32  step count of the move.
REQ-008 SHALL have port cmd_period  input  32  CLK cycles per step (rising edge to rising edge).
REQ-009 SHALL have port cmd_dir  input  1  direction of the move.
REQ-010 SHALL have port abort  input  1  stop the active move and flush the pending move.
REQ-011 SHALL have port step  output  1  step pulse to the stepper phase sequencer.
REQ-012 SHALL have port dir  output  1  direction to the stepper phase sequencer.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a move completes or an abort finishes.
REQ-015 SHALL have port steps_left  output  32  steps remaining in the active move.

Function
REQ-016 SHALL buffer commands in two registers: active move and pending move; cmd_ready = !pending_valid.
REQ-017 SHALL implement FSM states IDLE, LOAD, SETUP, HIGH, LOW.
REQ-018 IDLE -> LOAD on the edge where pending_valid=1; LOAD copies pending into active, clears pending_valid, and sets steps_left=cmd_steps.
REQ-019 LOAD -> IDLE with a done pulse if steps = 0; no step pulse is emitted.
REQ-020 LOAD -> SETUP if the new dir differs from the dir output, otherwise LOAD -> HIGH; the dir output updates on entry to SETUP.
REQ-021 SETUP SHALL last exactly DIR_SETUP cycles, then go to HIGH.
REQ-022 step SHALL be registered and equal 1 exactly while in HIGH.
REQ-023 HIGH SHALL last PULSE_W cycles; steps_left decrements by 1 on leaving HIGH.
REQ-024 LOW SHALL last (effective_period - PULSE_W) cycles, where effective_period = max(cmd_period, 2*PULSE_W).
REQ-025 When LOW expires with steps_left != 0, the FSM SHALL go to HIGH.
REQ-026 When LOW expires with steps_left = 0 and pending_valid = 1, the FSM SHALL go to LOAD (back-to-back move, no IDLE cycle).
REQ-027 When LOW expires with steps_left = 0 and pending_valid = 0, the FSM SHALL go to IDLE.
REQ-028 done SHALL pulse for 1 cycle on every completed move, including the back-to-back case, on the same edge that leaves LOW.
REQ-029 Period and pulse counters SHALL be 32-bit and never wrap; cmd_period = 0 or 1 is clamped per REQ-024.
REQ-030 A command accepted in the same cycle the pending slot is loaded into active SHALL NOT be lost; cmd_ready is deasserted until the slot is free.
REQ-031 abort in IDLE or LOAD SHALL flush pending and leave the FSM in IDLE, with a done pulse only if a move was in LOAD.
REQ-032 abort in SETUP or LOW SHALL go to IDLE on the next edge, zero steps_left, flush pending, and pulse done.
REQ-033 abort in HIGH SHALL complete the current PULSE_W high time, then go to IDLE with the same flush and done behaviour.
REQ-034 cmd_valid in the same cycle as abort SHALL NOT be accepted (cmd_ready is forced low while abort=1).
REQ-035 dir SHALL never change while busy, except on entry to SETUP.

Reset
REQ-036 Asserting reset SHALL immediately set state=IDLE, step=0, dir=0, busy=0, done=0, steps_left=0, pending_valid=0, and cmd_ready=1, independent of CLK.
REQ-037 Reset mid-move SHALL drop any step pulse in progress without completing it; after reset release, the first accepted command starts per REQ-018.

Verification
REQ-038 Scenario: steps=3, period=10, dir=0 from reset -> exactly 3 step pulses, each 4 cycles high, rising edges 10 cycles apart, done pulse once, steps_left 3->0.
REQ-039 Scenario: move A (steps=2, dir=0) then move B (steps=2, dir=1) queued during A -> dir toggles after A's last LOW, B's first step rises exactly 2 cycles after the dir change, and no IDLE cycle occurs between the moves.
REQ-040 Scenario: period=1 -> effective period = 8 cycles, with 4 cycles high and 4 cycles low.
REQ-041 Scenario: steps=0 -> no step pulse and a done pulse 2 cycles after command acceptance.
REQ-042 Scenario: abort asserted in the 2nd cycle of HIGH with a pending move -> step stays high for a full 4 cycles, then IDLE, pending flushed, and cmd_ready=1.
REQ-043 Scenario: reset asserted asynchronously mid-HIGH -> step=0 and busy=0 before the next CLK edge.

Source files
------------

// File: rtl/motion_sequencer.sv
// rtl/motion_sequencer.sv - step/dir move sequencer with one-deep command queue
module motion_sequencer #(
  parameter int unsigned PULSE_W   = 4,
  parameter int unsigned DIR_SETUP = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_steps,
  input  logic [31:0] cmd_period,
  input  logic        cmd_dir,
  input  logic        abort,
  output logic        step,
  output logic        dir,
  output logic        busy,
  output logic        done,
  output logic [31:0] steps_left
);

  localparam logic [31:0] PW     = 32'(PULSE_W);
  localparam logic [31:0] TWO_PW = 32'(2 * PULSE_W);
  localparam logic [31:0] DS     = 32'(DIR_SETUP);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    HIGH,
    LOW
  } state_t;

  state_t      state;
  logic        pending_valid;
  logic [31:0] pending_steps;
  logic [31:0] pending_low;
  logic        pending_dir;
  logic        active_dir;
  logic [31:0] active_low;
  logic [31:0] cnt;
  logic        abort_hold;
  logic        accept;
  logic [31:0] cmd_low;

  // Low time is stored precomputed: effective period minus the high time.
  assign cmd_low   = (cmd_period < TWO_PW) ? PW : (cmd_period - PW);
  assign cmd_ready = !pending_valid && !abort && !abort_hold;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pending_valid <= 1'b0;
      pending_steps <= 32'd0;
      pending_low   <= 32'd0;
      pending_dir   <= 1'b0;
      active_dir    <= 1'b0;
      active_low    <= 32'd0;
      cnt           <= 32'd0;
      abort_hold    <= 1'b0;
      step          <= 1'b0;
      dir           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      steps_left    <= 32'd0;
    end else begin
      done <= 1'b0;

      // Accept and load never coincide: accept needs an empty slot, load a full one.
      if (accept) begin
        pending_valid <= 1'b1;
        pending_steps <= cmd_steps;
        pending_low   <= cmd_low;
        pending_dir   <= cmd_dir;
      end

      case (state)
        IDLE: begin
          if (abort) begin
            pending_valid <= 1'b0;
          end else if (pending_valid) begin
            active_dir    <= pending_dir;
            active_low    <= pending_low;
            steps_left    <= pending_steps;
            pending_valid <= 1'b0;
            busy          <= 1'b1;
            state         <= LOAD;
          end
        end

        LOAD: begin
          if (abort) begin
            pending_valid <= 1'b0;
            steps_left    <= 32'd0;
            done          <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else if (steps_left == 32'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (active_dir != dir) begin
            dir   <= active_dir;
            cnt   <= DS;
            state <= SETUP;
          end else begin
            step  <= 1'b1;
            cnt   <= PW;
            state <= HIGH;
          end
        end

        SETUP: begin
          if (abort) begin
            pending_valid <= 1'b0;
            steps_left    <= 32'd0;
            done          <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else if (cnt <= 32'd1) begin
            step  <= 1'b1;
            cnt   <= PW;
            state <= HIGH;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        HIGH: begin
          // An abort here is remembered so the pulse finishes at full width.
          if (abort) begin
            abort_hold    <= 1'b1;
            pending_valid <= 1'b0;
          end
          if (cnt <= 32'd1) begin
            step <= 1'b0;
            if (abort || abort_hold) begin
              abort_hold    <= 1'b0;
              pending_valid <= 1'b0;
              steps_left    <= 32'd0;
              done          <= 1'b1;
              busy          <= 1'b0;
              state         <= IDLE;
            end else begin
              if (steps_left != 32'd0) begin
                steps_left <= steps_left - 32'd1;
              end
              cnt   <= active_low;
              state <= LOW;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        LOW: begin
          if (abort) begin
            pending_valid <= 1'b0;
            steps_left    <= 32'd0;
            done          <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else if (cnt <= 32'd1) begin
            if (steps_left != 32'd0) begin
              step  <= 1'b1;
              cnt   <= PW;
              state <= HIGH;
            end else begin
              done <= 1'b1;
              if (pending_valid) begin
                active_dir    <= pending_dir;
                active_low    <= pending_low;
                steps_left    <= pending_steps;
                pending_valid <= 1'b0;
                state         <= LOAD;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        default: begin
          step  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// tb/tb_motion_sequencer.sv - directed bench for motion_sequencer
module tb_motion_sequencer;

  logic        CLK;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_steps;
  logic [31:0] cmd_period;
  logic        cmd_dir;
  logic        abort;
  logic        step;
  logic        dir;
  logic        busy;
  logic        done;
  logic [31:0] steps_left;

  int vectors;
  int miscompares;

  logic        tr_step [200];
  logic        tr_done [200];
  logic        tr_busy [200];
  logic        tr_dir  [200];
  logic [31:0] tr_left [200];
  logic        pre_step;

  motion_sequencer #(.PULSE_W(4), .DIR_SETUP(2)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .cmd_dir    (cmd_dir),
    .abort      (abort),
    .step       (step),
    .dir        (dir),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic send(input logic [31:0] s, input logic [31:0] p, input logic d);
    cmd_steps  = s;
    cmd_period = p;
    cmd_dir    = d;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic run(input int n);
    pre_step = step;
    for (int i = 0; i < n; i++) begin
      tick();
      tr_step[i] = step;
      tr_done[i] = done;
      tr_busy[i] = busy;
      tr_dir[i]  = dir;
      tr_left[i] = steps_left;
    end
  endtask

  function automatic int nth_rise(input int k, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) begin
      if (tr_step[i] && !((i == 0) ? pre_step : tr_step[i-1])) begin
        if (c == k) return i;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic int count_rises(input int n);
    int c = 0;
    for (int i = 0; i < n; i++)
      if (tr_step[i] && !((i == 0) ? pre_step : tr_step[i-1])) c++;
    return c;
  endfunction

  function automatic int high_len(input int from, input int n);
    int c = 0;
    if (from < 0) return 0;
    for (int i = from; i < n && tr_step[i]; i++) c++;
    return c;
  endfunction

  function automatic int nth_done(input int k, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) begin
      if (tr_done[i]) begin
        if (c == k) return i;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic int count_done(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (tr_done[i]) c++;
    return c;
  endfunction

  function automatic int first_dir_high(input int n);
    for (int i = 0; i < n; i++) if (tr_dir[i]) return i;
    return -1;
  endfunction

  function automatic int busy_ones(input int from, input int to);
    int c = 0;
    for (int i = from; i <= to; i++) if (tr_busy[i]) c++;
    return c;
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_steps   = 32'd0;
    cmd_period  = 32'd0;
    cmd_dir     = 1'b0;
    abort       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_step", step, 1'b0);
    check("rst_dir", dir, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_left", steps_left, 32'd0);
    check("rst_ready", cmd_ready, 1'b1);

    // 3 steps, period 10
    send(32'd3, 32'd10, 1'b0);
    check("s1_ready_after_accept", cmd_ready, 1'b0);
    run(40);
    check("s1_rises", count_rises(40), 3);
    check("s1_rise0", nth_rise(0, 40), 1);
    check("s1_rise1", nth_rise(1, 40), 11);
    check("s1_rise2", nth_rise(2, 40), 21);
    check("s1_width0", high_len(nth_rise(0, 40), 40), 4);
    check("s1_width2", high_len(nth_rise(2, 40), 40), 4);
    check("s1_left_start", tr_left[0], 32'd3);
    check("s1_left_mid", tr_left[5], 32'd2);
    check("s1_left_end", tr_left[39], 32'd0);
    check("s1_done_cnt", count_done(40), 1);
    check("s1_done_at", nth_done(0, 40), 31);
    check("s1_busy_before", tr_busy[30], 1'b1);
    check("s1_busy_after", tr_busy[31], 1'b0);

    // back-to-back with direction change
    send(32'd2, 32'd10, 1'b0);
    tick();
    check("s2_ready_after_load", cmd_ready, 1'b1);
    send(32'd2, 32'd10, 1'b1);
    run(45);
    check("s2_rises", count_rises(45), 3);
    check("s2_a_rise2", nth_rise(0, 45), 9);
    check("s2_done_a", nth_done(0, 45), 19);
    check("s2_dir_change", first_dir_high(45), 20);
    check("s2_b_rise", nth_rise(1, 45), 22);
    check("s2_b_rise_after_dir", nth_rise(1, 45) - first_dir_high(45), 2);
    check("s2_no_idle", busy_ones(0, 41), 42);
    check("s2_done_b", nth_done(1, 45), 42);
    check("s2_busy_end", tr_busy[42], 1'b0);

    // period 1 clamps to 8
    send(32'd2, 32'd1, 1'b1);
    run(20);
    check("s3_rise0", nth_rise(0, 20), 1);
    check("s3_rise1", nth_rise(1, 20), 9);
    check("s3_width", high_len(nth_rise(0, 20), 20), 4);
    check("s3_low", nth_rise(1, 20) - nth_rise(0, 20) - high_len(nth_rise(0, 20), 20), 4);
    check("s3_done_at", nth_done(0, 20), 17);

    // zero-step move
    send(32'd0, 32'd10, 1'b1);
    run(6);
    check("s4_rises", count_rises(6), 0);
    check("s4_busy_load", tr_busy[0], 1'b1);
    check("s4_done_at", nth_done(0, 6), 1);
    check("s4_done_cnt", count_done(6), 1);

    // abort in the 2nd HIGH cycle with a move pending
    send(32'd5, 32'd10, 1'b1);
    tick();
    send(32'd7, 32'd10, 1'b0);
    check("s5_step_h1", step, 1'b1);
    check("s5_ready_full", cmd_ready, 1'b0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s5_step_h3", step, 1'b1);
    check("s5_ready_hold", cmd_ready, 1'b0);
    tick();
    check("s5_step_h4", step, 1'b1);
    tick();
    check("s5_step_off", step, 1'b0);
    check("s5_done", done, 1'b1);
    check("s5_busy", busy, 1'b0);
    check("s5_left", steps_left, 32'd0);
    check("s5_ready", cmd_ready, 1'b1);
    tick();
    check("s5_flushed_busy", busy, 1'b0);
    check("s5_done_once", done, 1'b0);
    check("s5_dir_kept", dir, 1'b1);

    // command offered together with abort is refused
    cmd_steps  = 32'd1;
    cmd_period = 32'd10;
    cmd_dir    = 1'b1;
    cmd_valid  = 1'b1;
    abort      = 1'b1;
    #1;
    check("s6_ready_abort", cmd_ready, 1'b0);
    tick();
    cmd_valid = 1'b0;
    abort     = 1'b0;
    tick();
    check("s6_not_accepted", busy, 1'b0);

    // asynchronous reset mid-HIGH
    send(32'd3, 32'd10, 1'b1);
    tick();
    tick();
    check("s7_step_pre", step, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("s7_step_rst", step, 1'b0);
    check("s7_busy_rst", busy, 1'b0);
    check("s7_dir_rst", dir, 1'b0);
    check("s7_left_rst", steps_left, 32'd0);
    check("s7_ready_rst", cmd_ready, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    send(32'd1, 32'd1, 1'b0);
    run(12);
    check("s7_post_rise", nth_rise(0, 12), 1);
    check("s7_post_done", nth_done(0, 12), 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
